// File: rtl/decode_issue_scoreboard.sv
// decode_issue_scoreboard: queued decode/issue stage with a RAW/WAW register scoreboard
module decode_issue_scoreboard #(
  parameter int WORD = 32,
  parameter int ADDR = 32,
  parameter int W_OPR = 32,
  parameter int W_RD = 5,
  parameter int W_IMM = 16,
  localparam int W_OPC = WORD - 2*W_RD - W_IMM,
  parameter int DEPTH = 2,
  parameter logic [2**W_OPC-1:0] IMM_MASK = '0,
  parameter logic [2**W_OPC-1:0] WB_MASK = '0,
  parameter logic [2**W_OPC-1:0] SEXT_MASK = '0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WORD-1:0]  in_inst,
  input  logic [ADDR-1:0]  in_pc,
  output logic [W_RD-1:0]  rf_ra0,
  output logic [W_RD-1:0]  rf_ra1,
  input  logic [W_OPR-1:0] rf_rd0,
  input  logic [W_OPR-1:0] rf_rd1,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [W_OPC-1:0] out_opcode,
  output logic [W_OPR-1:0] out_opr0,
  output logic [W_OPR-1:0] out_opr1,
  output logic [W_OPR-1:0] out_imm,
  output logic [ADDR-1:0]  out_pc,
  output logic [W_RD-1:0]  out_rd,
  output logic             out_wb,
  input  logic             ret_valid,
  input  logic [W_RD-1:0]  ret_rd,
  input  logic             flush
);
  localparam int NREG = 2**W_RD;
  localparam int W_PTR = $clog2(DEPTH);
  logic [WORD-1:0] q_inst [DEPTH];
  logic [ADDR-1:0] q_pc [DEPTH];
  logic [W_PTR-1:0] rd_ptr, wr_ptr;
  logic [W_PTR:0] count;
  logic [NREG-1:0] sb, sb_next;
  logic [WORD-1:0] head;
  logic [W_OPC-1:0] op;
  logic [W_RD-1:0] rd, rs;
  logic [W_IMM-1:0] imm;
  logic imm_f, wb_f, sext_f, hazard, issue, push;
  logic [W_OPR-1:0] imm_ext;

  assign head = q_inst[rd_ptr];
  assign op = head[WORD-1 -: W_OPC];
  assign rd = head[WORD-W_OPC-1 -: W_RD];
  assign rs = head[W_IMM+W_RD-1 -: W_RD];
  assign imm = head[W_IMM-1:0];
  assign imm_f = IMM_MASK[op];
  assign wb_f = WB_MASK[op] & (rd != '0);
  assign sext_f = SEXT_MASK[op];
  assign rf_ra0 = rd;
  assign rf_ra1 = rs;
  assign in_ready = count < (W_PTR+1)'(DEPTH);
  // rd doubles as source 0 and destination, so sb[rd] covers both RAW and WAW
  assign hazard = sb[rd] | (~imm_f & sb[rs]);
  assign issue = (count != '0) & ~hazard & (~out_valid | out_ready) & ~flush;
  assign push = in_valid & in_ready & ~flush;
  assign imm_ext = sext_f ? W_OPR'($signed(imm)) : W_OPR'(imm);

  // instruction queue: circular buffer, flush empties it without touching contents
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        q_inst[i] <= '0;
        q_pc[i] <= '0;
      end
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else if (flush) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
      count <= '0;
    end else begin
      if (push) begin
        q_inst[wr_ptr] <= in_inst;
        q_pc[wr_ptr] <= in_pc;
        wr_ptr <= wr_ptr + W_PTR'(1);
      end
      if (issue) rd_ptr <= rd_ptr + W_PTR'(1);
      count <= count + (W_PTR+1)'(push) - (W_PTR+1)'(issue);
    end
  end

  // scoreboard update: retire clears, issue sets afterwards so a same-register set wins
  always_comb begin
    sb_next = sb;
    if (ret_valid) sb_next[ret_rd] = 1'b0;
    if (issue && wb_f) sb_next[rd] = 1'b1;
    sb_next[0] = 1'b0;
  end

  // scoreboard register survives flush so in-flight writers still retire
  always_ff @(posedge clk or posedge reset) begin
    if (reset) sb <= '0;
    else sb <= sb_next;
  end

  // output register: capture on issue, hold under backpressure, drop on flush
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid <= 1'b0;
      out_opcode <= '0;
      out_opr0 <= '0;
      out_opr1 <= '0;
      out_imm <= '0;
      out_pc <= '0;
      out_rd <= '0;
      out_wb <= 1'b0;
    end else if (flush) begin
      out_valid <= 1'b0;
    end else if (issue) begin
      out_valid <= 1'b1;
      out_opcode <= op;
      out_opr0 <= rf_rd0;
      out_opr1 <= imm_f ? imm_ext : rf_rd1;
      out_imm <= imm_ext;
      out_pc <= q_pc[rd_ptr];
      out_rd <= rd;
      out_wb <= wb_f;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_decode_issue_scoreboard.sv
// tb_decode_issue_scoreboard: random stimulus checked against a queue-based model of the stage
module tb_decode_issue_scoreboard;
  localparam int DEPTH = 2;
  localparam logic [63:0] IMM_M = 64'h0000_0000_0000_FF00;
  localparam logic [63:0] WB_M = 64'hFFFF_FFFF_FFFF_FF0F;
  localparam logic [63:0] SEXT_M = 64'h0000_0000_0010_F000;

  logic clk, reset, in_valid, in_ready, out_valid, out_ready, out_wb, ret_valid, flush;
  logic [31:0] in_inst, in_pc, rf_rd0, rf_rd1, out_opr0, out_opr1, out_imm, out_pc;
  logic [4:0] rf_ra0, rf_ra1, out_rd, ret_rd;
  logic [5:0] out_opcode;
  logic [31:0] regs [32];

  typedef struct {logic [31:0] inst; logic [31:0] pc;} ent_t;
  typedef struct {logic [4:0] rd; int due;} pend_t;
  ent_t mq[$];
  pend_t pend[$];
  logic [31:0] sb;
  logic m_ov, m_wb;
  logic [5:0] m_op;
  logic [4:0] m_rd;
  logic [31:0] m_opr0, m_opr1, m_imm, m_pc;
  int cyc, n_tests, n_fail;

  decode_issue_scoreboard #(.DEPTH(DEPTH), .IMM_MASK(IMM_M), .WB_MASK(WB_M), .SEXT_MASK(SEXT_M)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_inst(in_inst),
    .in_pc(in_pc), .rf_ra0(rf_ra0), .rf_ra1(rf_ra1), .rf_rd0(rf_rd0), .rf_rd1(rf_rd1),
    .out_valid(out_valid), .out_ready(out_ready), .out_opcode(out_opcode), .out_opr0(out_opr0),
    .out_opr1(out_opr1), .out_imm(out_imm), .out_pc(out_pc), .out_rd(out_rd), .out_wb(out_wb),
    .ret_valid(ret_valid), .ret_rd(ret_rd), .flush(flush)
  );

  assign rf_rd0 = regs[rf_ra0];
  assign rf_rd1 = regs[rf_ra1];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  function automatic logic [31:0] mk(input int op, input int rd, input int rs, input logic [15:0] im);
    return {6'(op), 5'(rd), 5'(rs), im};
  endfunction

  task automatic model_clear();
    mq.delete();
    pend.delete();
    sb = '0;
    m_ov = 1'b0;
  endtask

  task automatic step(input logic iv, input logic [31:0] inst, input logic [31:0] pc, input logic ordy, input logic fl);
    logic rv, hz, iss, psh, imf, wbf, sxf;
    logic [4:0] rr, rd, rs;
    logic [5:0] op;
    logic [15:0] im;
    logic [31:0] ie, hi;
    @(negedge clk);
    rv = 1'b0;
    rr = '0;
    if (pend.size() > 0 && pend[0].due <= cyc) begin
      rv = 1'b1;
      rr = pend[0].rd;
      void'(pend.pop_front());
    end else if ($urandom_range(0, 19) == 0) begin
      rv = 1'b1;
      rr = 5'($urandom);
    end
    in_valid = iv; in_inst = inst; in_pc = pc; out_ready = ordy; flush = fl; ret_valid = rv; ret_rd = rr;
    #1;
    hi = mq.size() > 0 ? mq[0].inst : '0;
    op = 6'(hi >> 26);
    rd = 5'(hi >> 21);
    rs = 5'(hi >> 16);
    im = 16'(hi);
    imf = IMM_M[op];
    sxf = SEXT_M[op];
    wbf = WB_M[op] && rd != 0;
    ie = sxf ? 32'($signed(im)) : 32'(im);
    check("in_ready", in_ready, mq.size() < DEPTH);
    check("out_valid", out_valid, m_ov);
    if (m_ov) begin
      check("out_opcode", out_opcode, m_op);
      check("out_opr0", out_opr0, m_opr0);
      check("out_opr1", out_opr1, m_opr1);
      check("out_imm", out_imm, m_imm);
      check("out_pc", out_pc, m_pc);
      check("out_rd", out_rd, m_rd);
      check("out_wb", out_wb, m_wb);
    end
    if (mq.size() > 0) begin
      check("rf_ra0", rf_ra0, rd);
      check("rf_ra1", rf_ra1, rs);
    end
    hz = sb[rd] || (!imf && sb[rs]);
    iss = mq.size() > 0 && !hz && (!m_ov || ordy) && !fl;
    psh = iv && mq.size() < DEPTH && !fl;
    if (m_ov && (ordy || fl) && m_wb) pend.push_back('{m_rd, cyc + int'($urandom_range(1, 4))});
    if (rv) sb[rr] = 1'b0;
    if (iss && wbf) sb[rd] = 1'b1;
    if (fl) begin
      mq.delete();
      m_ov = 1'b0;
    end else begin
      if (iss) begin
        m_ov = 1'b1; m_op = op; m_rd = rd; m_wb = wbf; m_pc = mq[0].pc;
        m_opr0 = regs[rd]; m_imm = ie; m_opr1 = imf ? ie : regs[rs];
        void'(mq.pop_front());
      end else if (ordy) m_ov = 1'b0;
      if (psh) mq.push_back('{inst, pc});
    end
    cyc++;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_opcode"}, out_opcode, 0);
    check({tag, "_out_opr"}, {out_opr0, out_opr1}, 0);
    check({tag, "_out_imm_pc"}, {out_imm, out_pc}, 0);
    check({tag, "_out_rd_wb"}, {out_rd, out_wb}, 0);
    check({tag, "_rf_ra"}, {rf_ra0, rf_ra1}, 0);
  endtask

  task automatic rand_step(input int p_rdy, input int p_fl);
    step($urandom_range(0, 9) < 7,
         mk($urandom_range(0, 63), $urandom_range(0, 7), $urandom_range(0, 7), 16'($urandom)),
         $urandom, $urandom_range(0, 99) < p_rdy, $urandom_range(0, 99) < p_fl);
  endtask

  initial begin
    n_tests = 0; n_fail = 0; cyc = 0;
    for (int i = 0; i < 32; i++) regs[i] = $urandom;
    reset = 1'b1; in_valid = 0; in_inst = 0; in_pc = 0; out_ready = 0; ret_valid = 0; ret_rd = 0; flush = 0;
    model_clear();
    #1;
    check_reset_outputs("rst0");
    @(negedge clk);
    reset = 1'b0;
    step(1, mk(12, 3, 9, 16'hFFF0), 32'h100, 1, 0);
    step(1, mk(8, 7, 3, 16'hFFF0), 32'h104, 1, 0);
    step(0, 0, 0, 1, 0);
    check("sext_opr1", out_opr1, 32'hFFFF_FFF0);
    check("sext_imm", out_imm, 32'hFFFF_FFF0);
    step(0, 0, 0, 1, 0);
    check("zext_valid", out_valid, 1);
    check("zext_opr1", out_opr1, 32'h0000_FFF0);
    check("zext_rd", out_rd, 7);
    for (int i = 0; i < 3000; i++) rand_step(75, 3);
    for (int i = 0; i < 6; i++) rand_step(0, 0);
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    check_reset_outputs("rst_mid");
    model_clear();
    in_valid = 0; out_ready = 0; ret_valid = 0; flush = 0;
    @(negedge clk);
    reset = 1'b0;
    for (int i = 0; i < 500; i++) rand_step(85, 2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule

// File: doc/decode_issue_scoreboard.md
# decode_issue_scoreboard

Parametrised decode/issue stage that follows the fetch stage and feeds the execute stage. It buffers fetched instructions in a DEPTH-entry queue and decodes the queue head through per-opcode flag masks. An internal register scoreboard detects RAW and WAW hazards, so the stage needs no external reservation handshake. Operands are read from the register file at issue and are held in a ready/valid output register until execute accepts them.

## Interface
- WORD, 32, instruction width
- ADDR, 32, PC width
- W_OPR, 32, operand width
- W_RD, 5, register-index width; NREG = 2**W_RD
- W_IMM, 16, immediate width; W_OPC = WORD-2*W_RD-W_IMM
- DEPTH, 2, instruction queue entries (power of two, ≥2)
- IMM_MASK, WB_MASK, SEXT_MASK, 2**W_OPC bits each, 0; bit k set = opcode k uses immediate / writes back rd / sign-extends imm
---
- clk  in  1  clock, rising edge
- reset  in  1  asynchronous, active-high
- in_valid / in_ready  in/out  1  fetch handshake; transfer when both high
- in_inst  in  WORD  fields: [WORD-1:WORD-W_OPC] opcode, next W_RD rd, next W_RD rs, [W_IMM-1:0] imm
- in_pc  in  ADDR  PC of in_inst
- rf_ra0, rf_ra1  out  W_RD  regfile read addresses = head rd, head rs (combinational)
- rf_rd0, rf_rd1  in  W_OPR  regfile read data, combinational
- out_valid / out_ready  out/in  1  execute handshake
- out_opcode  out  W_OPC; out_opr0, out_opr1, out_imm  out  W_OPR; out_pc  out  ADDR
- out_rd  out  W_RD; out_wb  out  1  instruction writes rd
- ret_valid, ret_rd  in  1, W_RD  writeback retirement; clears scoreboard bit
- flush  in  1  branch redirect

## Operation
- Queue: circular buffer with rd/wr pointers and count (0..DEPTH). in_ready = (count < DEPTH), a registered-state function only; a same-cycle pop does not raise it.
- Head flags: imm_f = IMM_MASK[op], wb_f = WB_MASK[op] and rd≠0, sext_f = SEXT_MASK[op].
- Hazard = sb[rd] | (~imm_f & sb[rs]). rd is both source 0 and destination, so sb[rd] also covers WAW. Register 0 is never marked busy.
- issue = count>0 & ~hazard & (~out_valid | out_ready) & ~flush.
- On issue, capture into the output register:
  - opcode, pc, rd, wb_f
  - opr0 = rf_rd0
  - imm = sext_f ? sign-extend(imm) : zero-extend(imm) to W_OPR
  - opr1 = imm_f ? imm : rf_rd1
  - set sb[rd] if wb_f; pop the queue.
- Retire: ret_valid clears sb[ret_rd]. If a retire and an issue-set hit the same register in one cycle, the set wins.
- No bypass: a bit cleared in cycle N allows issue in cycle N+1 at the earliest.
- Output register: out_valid is set on issue. It is cleared when out_ready is high and no new issue occurs. Fields stay stable while out_valid & ~out_ready.
- Flush:
  - count → 0 and pointers reset next edge; out_valid → 0.
  - in_valid during a flush is dropped.
  - Scoreboard is NOT cleared, so in-flight writes still retire.
- Push and pop in the same cycle keep count unchanged.

## Timing
- Reset: all outputs 0 (in_ready=1 because count=0). Queue, pointers, count, scoreboard and output register are all cleared asynchronously. A reset mid-stream discards everything.
- Latency: instruction accepted at edge E0 → may issue at E1 → out_valid high after E1. Minimum is 2 edges.
- Throughput: 1 instruction/cycle with no hazards and out_ready held high.
- A hazard stall holds the head in place and does not block the queue from filling to DEPTH.
- Output backpressure (out_valid & ~out_ready) blocks issue but not enqueue.
- flush has priority over issue, push and out_valid hold.

## Test plan
- Back-to-back independent ALU ops (r1←r1+r2, r3←r3+r4), out_ready=1, ret each 1 cycle after out → out_valid continuous after first 2 edges, one instr/cycle, sb clears.
- RAW: op writes r5, next reads r5 as rs; ret_valid for r5 delayed 4 cycles → second held; out_valid rises on the edge after the cycle ret_valid=1.
- Immediate: opcode with IMM+SEXT, imm=16'hFFF0 → out_opr1=32'hFFFFFFF0; same imm without SEXT → 32'h0000FFF0; sb[rs] set does not stall.
- Backpressure: out_ready=0 for 5 cycles, feed 4 instrs with DEPTH=2 → out fields stable, in_ready low after count=2, no loss or duplication when released.
- Flush with queue full and out_valid=1, plus in_valid=1 same cycle → next cycle count=0, out_valid=0, dropped instr never appears. sb bit of an issued in-flight writer stays set until its ret_valid.
- Async reset asserted mid-stall → all outputs 0 immediately, in_ready=1, sb empty.
